// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch-side blocks.
//   fetch_state_t : fetch sequencer FSM states
//   XLEN_DEF, RESET_PC_DEF, TRAP_VEC_DEF : parameter defaults
//   INSTR_BYTES   : sequential PC step
package core_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    localparam int          XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
    localparam logic [63:0] TRAP_VEC_DEF = 64'h100;
    localparam int          INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux for the fetch sequencer.
// Priority: trap > redirect > sequential advance > hold.
// Ports:
//   pc             in   current PC
//   advance        in   decode accepted the held instruction this cycle
//   trap_valid     in   trap request
//   redirect_valid in   branch/jump redirect
//   redirect_pc    in   redirect target
//   next_pc        out  PC to load at the next edge
//   flush          out  a trap or redirect is taking effect
//   misalign       out  the selected redirect target is not word aligned
module pc_next_sel
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            misalign
);

    always_comb begin
        next_pc  = pc;
        misalign = 1'b0;
        if (trap_valid) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            // A misaligned target is turned into a trap rather than fetched.
            if (redirect_pc[1:0] != 2'b00) begin
                next_pc  = TRAP_VEC;
                misalign = 1'b1;
            end else begin
                next_pc = redirect_pc;
            end
        end else if (advance) begin
            next_pc = pc + XLEN'(INSTR_BYTES);
        end
    end

    assign flush = trap_valid | redirect_valid;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller owning the program counter.
// Issues instruction-memory requests, holds each returned word for decode
// under a valid/ready handshake, applies traps/redirects and discards
// fetches that were in flight when a redirect arrived.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   fetch request (addr always equals pc_out)
//   imem_gnt        request accepted
//   imem_rvalid/rdata  read response
//   instr_valid/instr/instr_pc  held instruction to decode
//   instr_ready     decode accepts the held instruction
//   redirect_valid/redirect_pc  branch/jump from execute
//   trap_valid      trap request
//   halt/resume     stop fetching after a handoff / restart
//   misalign_err    one-cycle pulse on a misaligned redirect
//   pc_out          current PC
//   instret         instructions accepted by decode
module pc_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            halt,
    input  logic            resume,
    output logic            misalign_err,
    output logic [XLEN-1:0] pc_out,
    output logic [63:0]     instret
);

    fetch_state_t    state;
    logic            kill;      // outstanding fetch is stale, drop its data
    logic [XLEN-1:0] next_pc;
    logic            flush;
    logic            misalign;
    logic            handoff;

    assign handoff   = (state == HOLD) && instr_ready;
    assign imem_addr = pc_out;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .pc             (pc_out),
        .advance        (handoff),
        .trap_valid     (trap_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc),
        .flush          (flush),
        .misalign       (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc_out       <= RESET_PC;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
            instret      <= '0;
            kill         <= 1'b0;
        end else begin
            pc_out       <= next_pc;
            misalign_err <= misalign;
            if (handoff)
                instret <= instret + 64'd1;

            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    // Without gnt the new PC is simply presented next cycle.
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        kill     <= flush;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || flush) begin
                            kill     <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_out;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state <= HALT;
                        end else begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (resume || flush) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven bench for pc_sequencer.
// Each record holds the inputs for one clock edge and the outputs expected
// just after that edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        misalign_err;
    logic [63:0] pc_out;
    logic [63:0] instret;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .halt           (halt),
        .resume         (resume),
        .misalign_err   (misalign_err),
        .pc_out         (pc_out),
        .instret        (instret)
    );

    typedef struct {
        logic        rst, gnt, rv;
        logic [31:0] rdata;
        logic        rdy, rd;
        logic [63:0] rpc;
        logic        trap, hlt, res;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic [63:0] e_ipc;
        logic        e_mis;
        logic [63:0] e_iret;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic rs, g, r, input logic [31:0] d, input logic rdy, rd,
        input logic [63:0] rpc, input logic tr, h, rs2,
        input logic er, input logic [63:0] ea, input logic ev,
        input logic [31:0] ei, input logic [63:0] ep, input logic em,
        input logic [63:0] en);
        vec_t v;
        v.rst = rs; v.gnt = g; v.rv = r; v.rdata = d; v.rdy = rdy; v.rd = rd;
        v.rpc = rpc; v.trap = tr; v.hlt = h; v.res = rs2;
        v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_instr = ei;
        v.e_ipc = ep; v.e_mis = em; v.e_iret = en;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
        instr_ready = v.rdy; redirect_valid = v.rd; redirect_pc = v.rpc;
        trap_valid = v.trap; halt = v.hlt; resume = v.res;
        @(posedge clk);
        #1;
        n_vec++;
        if (imem_req !== v.e_req || imem_addr !== v.e_addr || pc_out !== v.e_addr ||
            instr_valid !== v.e_val || instr !== v.e_instr || instr_pc !== v.e_ipc ||
            misalign_err !== v.e_mis || instret !== v.e_iret) begin
            n_bad++;
            $display("FAIL vec %0d: got req=%b addr=%h pc=%h val=%b instr=%h ipc=%h mis=%b iret=%0d, want req=%b addr=%h val=%b instr=%h ipc=%h mis=%b iret=%0d",
                     idx, imem_req, imem_addr, pc_out, instr_valid, instr, instr_pc,
                     misalign_err, instret, v.e_req, v.e_addr, v.e_val, v.e_instr,
                     v.e_ipc, v.e_mis, v.e_iret);
        end
    endtask

    localparam logic [31:0] I0 = 32'h0000_0013, I1 = 32'h0010_0093,
                            I2 = 32'h0020_0113, I3 = 32'h0030_0193,
                            I4 = 32'h0040_0213, I5 = 32'h0050_0293,
                            I6 = 32'h0060_0313, I7 = 32'h0070_0393,
                            DD = 32'hDEAD_BEEF;
    localparam logic [63:0] TV = 64'h100;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        //           rst g r data rdy rd rpc    tr h rs | req addr   val instr ipc   mis iret
        // reset, then steady fetch at 0,4,8,12
        tbl.push_back(mk(1,0,0,0 ,0,0,0     ,0,0,0, 0,64'h0  ,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,0,0,0 ,0,0,0     ,0,0,0, 1,64'h0  ,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h0  ,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,0,1,I0,0,0,0     ,0,0,0, 0,64'h0  ,1,I0,64'h0  ,0,0));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'h4  ,0,I0,64'h0  ,0,1));
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h4  ,0,I0,64'h0  ,0,1));
        tbl.push_back(mk(0,0,1,I1,0,0,0     ,0,0,0, 0,64'h4  ,1,I1,64'h4  ,0,1));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'h8  ,0,I1,64'h4  ,0,2));
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h8  ,0,I1,64'h4  ,0,2));
        tbl.push_back(mk(0,0,1,I2,0,0,0     ,0,0,0, 0,64'h8  ,1,I2,64'h8  ,0,2));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'hC  ,0,I2,64'h8  ,0,3));
        // decode stalls 5 cycles in HOLD
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'hC  ,0,I2,64'h8  ,0,3));
        tbl.push_back(mk(0,0,1,I3,0,0,0     ,0,0,0, 0,64'hC  ,1,I3,64'hC  ,0,3));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0  ,0,0,0, 0,64'hC  ,1,I3,64'hC  ,0,3));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'h10 ,0,I3,64'hC  ,0,4));
        // redirect during WAIT: returning word dropped
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h10 ,0,I3,64'hC  ,0,4));
        tbl.push_back(mk(0,0,0,0 ,0,1,64'h200,0,0,0,0,64'h200,0,I3,64'hC  ,0,4));
        tbl.push_back(mk(0,0,1,DD,0,0,0     ,0,0,0, 1,64'h200,0,I3,64'hC  ,0,4));
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h200,0,I3,64'hC  ,0,4));
        tbl.push_back(mk(0,0,1,I4,0,0,0     ,0,0,0, 0,64'h200,1,I4,64'h200,0,4));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'h204,0,I4,64'h200,0,5));
        // trap beats redirect; misaligned redirect pulses misalign_err once
        tbl.push_back(mk(0,0,0,0 ,0,1,64'h300,1,0,0,1,TV     ,0,I4,64'h200,0,5));
        tbl.push_back(mk(0,0,0,0 ,0,1,64'h202,0,0,0,1,TV     ,0,I4,64'h200,1,5));
        tbl.push_back(mk(0,0,0,0 ,0,0,0     ,0,0,0, 1,TV     ,0,I4,64'h200,0,5));
        // halt on handoff, 4 quiet cycles, resume at pc+4
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,TV     ,0,I4,64'h200,0,5));
        tbl.push_back(mk(0,0,1,I5,0,0,0     ,0,0,0, 0,TV     ,1,I5,TV     ,0,5));
        tbl.push_back(mk(0,0,0,0 ,1,0,0     ,0,1,0, 0,64'h104,0,I5,TV     ,0,6));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0  ,0,0,0, 0,64'h104,0,I5,TV     ,0,6));
        tbl.push_back(mk(0,0,0,0 ,0,0,0     ,0,0,1, 1,64'h104,0,I5,TV     ,0,6));
        // reset in WAIT, stale rvalid afterwards is ignored
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h104,0,I5,TV     ,0,6));
        tbl.push_back(mk(1,0,0,0 ,0,0,0     ,0,0,0, 0,64'h0  ,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,0,1,DD,0,0,0     ,0,0,0, 1,64'h0  ,0,0 ,64'h0  ,0,0));
        // redirect with gnt in the same cycle -> killed fetch
        tbl.push_back(mk(0,1,0,0 ,0,1,64'h400,0,0,0,0,64'h400,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,0,1,DD,0,0,0     ,0,0,0, 1,64'h400,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h400,0,0 ,64'h0  ,0,0));
        tbl.push_back(mk(0,0,1,I6,0,0,0     ,0,0,0, 0,64'h400,1,I6,64'h400,0,0));
        // redirect with handoff in HOLD: counted, pc takes the redirect
        tbl.push_back(mk(0,0,0,0 ,1,1,64'h500,0,0,0,1,64'h500,0,I6,64'h400,0,1));
        // redirect together with rvalid in WAIT: data dropped
        tbl.push_back(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h500,0,I6,64'h400,0,1));
        tbl.push_back(mk(0,0,1,DD,0,1,64'h600,0,0,0,1,64'h600,0,I6,64'h400,0,1));

        @(posedge clk);
        #1;
        foreach (tbl[i])
            run_vec(tbl[i], i);

        // PC wraps to 0 after the top word is handed off
        run_vec(mk(0,0,0,0 ,0,1,TOP   ,0,0,0, 1,TOP   ,0,I6,64'h400,0,1), 100);
        run_vec(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,TOP   ,0,I6,64'h400,0,1), 101);
        run_vec(mk(0,0,1,I7,0,0,0     ,0,0,0, 0,TOP   ,1,I7,TOP    ,0,1), 102);
        run_vec(mk(0,0,0,0 ,1,0,0     ,0,0,0, 1,64'h0 ,0,I7,TOP    ,0,2), 103);
        // trap while halted restarts fetch at the trap vector
        run_vec(mk(0,1,0,0 ,0,0,0     ,0,0,0, 0,64'h0 ,0,I7,TOP    ,0,2), 104);
        run_vec(mk(0,0,1,I0,0,0,0     ,0,0,0, 0,64'h0 ,1,I0,64'h0  ,0,2), 105);
        run_vec(mk(0,0,0,0 ,1,0,0     ,0,1,0, 0,64'h4 ,0,I0,64'h0  ,0,3), 106);
        run_vec(mk(0,0,0,0 ,0,0,0     ,1,0,0, 1,TV    ,0,I0,64'h0  ,0,3), 107);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller that owns the 64-bit program counter.
- Sequences instruction-memory requests, then hands each fetched instruction to decode with a valid/ready handshake.
- Applies redirects from execute (branch/jump) and traps, and discards stale fetches after a redirect.
- Sits between the PC register stage and the instruction memory / decode stage of the RISC-V core; it replaces open-loop PC stepping.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 64'h0, PC value loaded on reset.
- TRAP_VEC, 64'h100, target PC for traps and misaligned redirects.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; always equals pc_out.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid, at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instruction available to decode.
- instr  output  32  held instruction.
- instr_pc  output  XLEN  PC of the held instruction.
- instr_ready  input  1  decode accepts the instruction.
- redirect_valid  input  1  branch taken or jump from execute.
- redirect_pc  input  XLEN  redirect target.
- trap_valid  input  1  exception/trap request.
- halt  input  1  stop fetching after the current handoff.
- resume  input  1  leave HALT.
- misalign_err  output  1  one-cycle pulse when redirect_pc[1:0] != 0.
- pc_out  output  XLEN  current PC register.
- instret  output  64  count of instructions accepted by decode.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - pc_out = RESET_PC; state = IDLE.
  - imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
  - misalign_err = 0, instret = 0, kill = 0.
  - rst has priority over every other input.
- States: IDLE, REQ, WAIT, HOLD, HALT.
  - IDLE: one cycle after reset -> REQ.
  - REQ: imem_req = 1, imem_addr = pc_out. On imem_gnt -> WAIT. imem_req deasserts in WAIT/HOLD/HALT/IDLE.
  - WAIT: on imem_rvalid:
    - if kill = 1: drop the data, clear kill -> REQ.
    - else: latch instr = imem_rdata and instr_pc = pc_out, set instr_valid = 1 -> HOLD.
  - HOLD: instr_valid stays 1 and instr is stable until instr_ready. On instr_ready:
    - pc_out <= pc_out + 4 (modulo 2^XLEN, wraps to 0).
    - instret increments.
    - instr_valid drops next cycle.
    - -> HALT if halt is high that cycle, else -> REQ.
  - HALT: no requests. resume -> REQ. trap_valid or redirect_valid also apply and -> REQ.
- Redirect/trap priority: trap > redirect > sequential. All take effect at the next edge.
  - trap_valid: pc_out <= TRAP_VEC.
  - redirect_valid with redirect_pc[1:0] == 0: pc_out <= redirect_pc.
  - redirect_valid with misaligned target: pc_out <= TRAP_VEC and misalign_err pulses for one cycle.
- Redirect/trap effect by state:
  - REQ without gnt: stay in REQ; the new address is presented next cycle.
  - REQ with gnt in the same cycle: -> WAIT with kill = 1.
  - WAIT: kill <= 1; state is unchanged until rvalid.
  - WAIT with rvalid in the same cycle: the data is dropped -> REQ.
  - HOLD: instr_valid <= 0 and -> REQ. If instr_ready is high in the same cycle, the handoff still counts (instret increments), but pc_out takes the redirect value, not +4.
- Stale-fetch guarantee: a killed fetch never raises instr_valid.
- Counter: instret is 64 bits and wraps at 2^64.
- Reset mid-transaction: any outstanding rvalid arriving after reset is ignored, because the FSM is in IDLE/REQ and kill = 0. Memory is required to drop its response on rst.

Decomposition:
- Shared package core_pkg:
  - state enum fetch_state_t (IDLE, REQ, WAIT, HOLD, HALT).
  - XLEN, RESET_PC and TRAP_VEC defaults.
  - localparam INSTR_BYTES = 4.
- One sub-module: pc_next_sel, combinational next-PC mux (trap/redirect/+4/hold) with misalign detection. FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then steady fetch, gnt immediate, rvalid 1 cycle later, instr_ready = 1 -> imem_addr sequence 0, 4, 8, 12; instret = 3 after the third handoff.
- instr_ready held low 5 cycles in HOLD -> instr and instr_pc stable, no new imem_req, pc_out unchanged.
- redirect_valid with redirect_pc = 0x200 during WAIT -> returning word dropped, next imem_addr = 0x200, instr_valid never asserted for the old fetch.
- trap_valid and redirect_valid (0x300) in the same cycle -> pc_out = TRAP_VEC (0x100).
- redirect_pc = 0x202 -> misalign_err = 1 for exactly one cycle, pc_out = 0x100.
- halt during HOLD with instr_ready -> HALT, no imem_req for 4 cycles; resume -> fetch at pc + 4. rst asserted in WAIT -> pc_out = RESET_PC next cycle and all outputs at reset values.
